// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator.
// - pc_src_e : redirect source selected for the next PC. The fetch debug
//              trace uses the same encoding.
// - DEFAULT_RESET_VECTOR / DEFAULT_INC : default parameter values for pc_gen.
// - is_pow2  : helper for the parameter sanity checks.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SRC_SEQ,
        PC_SRC_CALL,
        PC_SRC_RET,
        PC_SRC_BRANCH,
        PC_SRC_TRAP
    } pc_src_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned DEFAULT_INC          = 4;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   flush           discard all entries (count -> 0)
//   push, push_data write push_data at top+1 and advance top
//   pop             retreat top; the caller guarantees count != 0
//   top_data        entry at the current top pointer
//   count           number of valid entries, saturating at RAS_DEPTH
// The caller never asserts push and pop together.
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [XLEN-1:0]              push_data,
    input  logic                         pop,
    output logic [XLEN-1:0]              top_data,
    output logic [$clog2(RAS_DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   top;
    logic [XLEN-1:0] entry [RAS_DEPTH];

    // Pointer and occupancy. A flush only clears the count. The pointer
    // position does not matter once the count is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push) begin
            top <= top + PW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            top   <= top - PW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage needs no reset. Its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            entry[top + PW'(1)] <= push_data;
        end
    end

    assign top_data = entry[top];

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter generator with a prioritised redirect network
// (trap > stall > branch > return > call > sequential) and a return-address
// stack for call/return prediction.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   stall                     hold PC and RAS; only a trap overrides it
//   trap_valid/trap_target    trap redirect, also flushes the RAS
//   branch_taken/branch_target resolved branch redirect
//   ret_valid                 return: predict from the RAS when it is non-empty
//   call_valid/call_target    call: jump and push pc + INC
//   pc                        registered fetch address
//   ras_count/ras_empty       RAS occupancy
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int unsigned      INC          = DEFAULT_INC,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        trap_valid,
    input  logic [XLEN-1:0]             trap_target,
    input  logic                        branch_taken,
    input  logic [XLEN-1:0]             branch_target,
    input  logic                        ret_valid,
    input  logic                        call_valid,
    input  logic [XLEN-1:0]             call_target,
    output logic [XLEN-1:0]             pc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_empty
);

    // Clears the low log2(INC) bits of a loaded target.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC) - XLEN'(1));

    if (!is_pow2(INC)) begin : g_bad_inc
        $error("pc_gen: INC must be a power of 2");
    end
    if (!is_pow2(RAS_DEPTH) || RAS_DEPTH < 2) begin : g_bad_depth
        $error("pc_gen: RAS_DEPTH must be a power of 2 and at least 2");
    end
    if ((RESET_VECTOR & ~ALIGN_MASK) != '0) begin : g_bad_rv
        $error("pc_gen: RESET_VECTOR must be INC-aligned");
    end

    pc_src_e         src;
    logic            hold;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_flush;
    logic            ras_push;
    logic            ras_pop;

    assign pc_inc = pc + XLEN'(INC);

    // Priority select. A return with an empty RAS falls back to the
    // sequential path. It must not also be treated as a call.
    always_comb begin
        src  = PC_SRC_SEQ;
        hold = 1'b0;
        if (trap_valid) begin
            src = PC_SRC_TRAP;
        end else if (stall) begin
            hold = 1'b1;
        end else if (branch_taken) begin
            src = PC_SRC_BRANCH;
        end else if (ret_valid) begin
            if (!ras_empty) begin
                src = PC_SRC_RET;
            end
        end else if (call_valid) begin
            src = PC_SRC_CALL;
        end
    end

    assign ras_flush = (src == PC_SRC_TRAP);
    assign ras_push  = (src == PC_SRC_CALL);
    assign ras_pop   = (src == PC_SRC_RET);

    always_comb begin
        pc_next = pc_inc;
        if (hold) begin
            pc_next = pc;
        end else begin
            case (src)
                PC_SRC_TRAP:   pc_next = trap_target & ALIGN_MASK;
                PC_SRC_BRANCH: pc_next = branch_target & ALIGN_MASK;
                PC_SRC_RET:    pc_next = ras_top;
                PC_SRC_CALL:   pc_next = call_target & ALIGN_MASK;
                default:       pc_next = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    return_addr_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .flush     (ras_flush),
        .push      (ras_push),
        .push_data (pc_inc),
        .pop       (ras_pop),
        .top_data  (ras_top),
        .count     (ras_count)
    );

    assign ras_empty = (ras_count == '0);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen (XLEN=32, RESET_VECTOR=0, INC=4, RAS_DEPTH=4).
// The driver applies inputs on the falling edge. It updates a queue-based
// reference model and pushes the expected state. A monitor pops one entry
// per sample and compares it with the DUT.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ret_valid;
    logic        call_valid;
    logic [31:0] call_target;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_empty;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INC          (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .trap_valid    (trap_valid),
        .trap_target   (trap_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ret_valid     (ret_valid),
        .call_valid    (call_valid),
        .call_target   (call_target),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty)
    );

    typedef struct {
        logic [31:0] pc;
        int unsigned cnt;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    event        sample_ev;

    // Reference model: the PC value, plus a plain list of return addresses.
    // The newest entry is at the back of the list.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    function automatic void model_reset();
        m_pc = 32'h0;
        m_ras.delete();
    endfunction

    function automatic void model_step();
        logic [31:0] nxt;
        nxt = m_pc + 32'd4;
        if (trap_valid) begin
            m_pc = {trap_target[31:2], 2'b00};
            m_ras.delete();
        end else if (stall) begin
            // everything holds
        end else if (branch_taken) begin
            m_pc = {branch_target[31:2], 2'b00};
        end else if (ret_valid) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else                  m_pc = nxt;
        end else if (call_valid) begin
            m_ras.push_back(nxt);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            m_pc = {call_target[31:2], 2'b00};
        end else begin
            m_pc = nxt;
        end
    endfunction

    task automatic expect_now(input string nm);
        exp_t e;
        e.pc   = m_pc;
        e.cnt  = m_ras.size();
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        stall = 0; trap_valid = 0; trap_target = 0; branch_taken = 0;
        branch_target = 0; ret_valid = 0; call_valid = 0; call_target = 0;
    endtask

    task automatic drive(input string nm, input bit st, input bit tr, input logic [31:0] tt,
                         input bit br, input logic [31:0] bt, input bit rt,
                         input bit cl, input logic [31:0] ct);
        @(negedge clk);
        rst = 0;
        stall = st; trap_valid = tr; trap_target = tt;
        branch_taken = br; branch_target = bt;
        ret_valid = rt; call_valid = cl; call_target = ct;
        model_step();
        expect_now(nm);
    endtask

    task automatic idle(input string nm);
        drive(nm, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    // Raise reset in the middle of a cycle. Check the effect straight away,
    // then again at the following edge while reset is still high.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #2;
        rst = 1;
        clear_inputs();
        model_reset();
        #1;
        expect_now(nm);
        -> sample_ev;
        expect_now({nm, "_hold"});
    endtask

    // Regular sampling point, one time unit after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        -> sample_ev;
    end

    // Monitor / comparator.
    initial forever begin
        exp_t e;
        @(sample_ev);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (pc !== e.pc) begin
                bad++;
                $display("FAIL %s pc: got %h want %h", e.name, pc, e.pc);
            end
            total++;
            if (ras_count !== 3'(e.cnt)) begin
                bad++;
                $display("FAIL %s ras_count: got %0d want %0d", e.name, ras_count, e.cnt);
            end
            total++;
            if (ras_empty !== (e.cnt == 0)) begin
                bad++;
                $display("FAIL %s ras_empty: got %b want %b", e.name, ras_empty, (e.cnt == 0));
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r;
        logic [31:0] rt_tgt;
        rst = 1;
        clear_inputs();
        model_reset();

        // Reset state, then sequential stepping.
        @(negedge clk);
        expect_now("reset_state");
        idle("seq1"); idle("seq2"); idle("seq3");
        for (int i = 0; i < 16 && m_pc != 32'h20; i++) idle("seq_to_20");
        async_reset("async_rst");

        // Single call and return.
        for (int i = 0; i < 16 && m_pc != 32'h10; i++) idle("seq_to_10");
        drive("call_200", 0, 0, 0, 0, 0, 0, 1, 32'h200);
        idle("after_call");
        drive("ret_14", 0, 0, 0, 0, 0, 1, 0, 0);

        // Nested calls saturate the RAS, then the oldest return is lost.
        drive("br_100", 0, 0, 0, 1, 32'h100, 0, 0, 0);
        drive("call1", 0, 0, 0, 0, 0, 0, 1, 32'h200);
        idle("n1");
        drive("call2", 0, 0, 0, 0, 0, 0, 1, 32'h300);
        idle("n2");
        drive("call3", 0, 0, 0, 0, 0, 0, 1, 32'h400);
        idle("n3");
        drive("call4", 0, 0, 0, 0, 0, 0, 1, 32'h500);
        idle("n4");
        drive("call5_sat", 0, 0, 0, 0, 0, 0, 1, 32'h600);
        for (int i = 0; i < 5; i++) drive("nested_ret", 0, 0, 0, 0, 0, 1, 0, 0);

        // Stall drops a branch. A trap overrides the stall and flushes the RAS.
        drive("call_700", 0, 0, 0, 0, 0, 0, 1, 32'h700);
        for (int i = 0; i < 3; i++) drive("stall_br", 1, 0, 0, 1, 32'h80, 0, 0, 0);
        drive("stall_trap", 1, 1, 32'h1000, 0, 0, 0, 0, 0);

        // Same-cycle priority.
        drive("call_900", 0, 0, 0, 0, 0, 0, 1, 32'h900);
        drive("trap_br_call", 0, 1, 32'h1000, 1, 32'h80, 0, 1, 32'h40);
        drive("call_2000", 0, 0, 0, 0, 0, 0, 1, 32'h2000);
        drive("br83_ret", 0, 0, 0, 1, 32'h83, 1, 0, 0);
        drive("call_3000", 0, 0, 0, 0, 0, 0, 1, 32'h3000);
        drive("ret_call", 0, 0, 0, 0, 0, 1, 1, 32'h5000);
        drive("misaligned_trap", 0, 1, 32'h1237, 0, 0, 0, 0, 0);

        // Wrap at the top of the address space.
        drive("br_top", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        drive("call_wrap", 0, 0, 0, 0, 0, 0, 1, 32'h40);
        drive("ret_wrap", 0, 0, 0, 0, 0, 1, 0, 0);
        drive("br_top2", 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        idle("seq_wrap");

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                async_reset("rnd_rst");
            end else begin
                rt_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
                drive("rnd",
                      ($urandom_range(0, 99) < 15),
                      ($urandom_range(0, 99) < 3), $urandom,
                      ($urandom_range(0, 99) < 10), rt_tgt,
                      ($urandom_range(0, 99) < 25),
                      ($urandom_range(0, 99) < 25), rt_tgt ^ 32'h0000_0100);
            end
        end

        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
